dmem_responder: RTL and testbench

- Multi-cycle data-memory responder. It sits on the processor data port, on the same dAddress / dWriteData / dReadData / MemRead / MemWrite bus the core drives.
- Serves one word-aligned load or store per transaction after a programmable wait-state latency.
- Signals completion with a one-cycle MemReady pulse and flags illegal accesses with MemError.
- Replaces the single-cycle data memory so the core's stall logic can be exercised.

---
 rtl/dmem_responder.sv | 116 +++++++++++
 tb/tb_dmem_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the processor data port.
// Captures one load/store per transaction, waits a programmable number of
// cycles, then reports completion with a one-cycle MemReady pulse that is
// qualified by MemError for misaligned, out-of-range or conflicting accesses.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 32,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned AW          = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] dAddress,
    input  logic [31:0]   dWriteData,
    input  logic          MemRead,
    input  logic          MemWrite,
    output logic [31:0]   dReadData,
    output logic          MemReady,
    output logic          MemError
);

    localparam int unsigned IW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [AW:0] BYTE_LIMIT = (AW+1)'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t         state_q;
    logic [3:0]     cnt_q;
    logic [AW-1:0]  addr_q;
    logic [31:0]    wdata_q;
    logic           rd_q;
    logic           wr_q;
    logic [31:0]    rdata_q;
    logic           ready_q;
    logic           error_q;
    logic [31:0]    mem_q [DEPTH_WORDS];

    logic           misaligned;
    logic           out_of_range;
    logic           conflict;
    logic           access_err;
    logic [IW-1:0]  idx;

    // Access legality and storage index, derived only from captured values.
    always_comb begin
        misaligned   = (addr_q[1:0] != 2'b00);
        out_of_range = ({1'b0, addr_q} >= BYTE_LIMIT);
        conflict     = rd_q & wr_q;
        access_err   = misaligned | out_of_range | conflict;
        idx          = addr_q[IW+1:2];
    end

    // Transaction FSM, wait counter, storage and registered bus outputs.
    // The pulse is registered from the RESP state, so MemReady rises on the
    // edge leaving RESP; load data is latched on that same edge so it is
    // already valid while MemReady is visible, and the FSM is then free to
    // capture a still-held request as the next transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ready_q <= (state_q == RESP);
            error_q <= (state_q == RESP) && access_err;
            case (state_q)
                IDLE: begin
                    if (MemRead | MemWrite) begin
                        addr_q  <= dAddress;
                        wdata_q <= dWriteData;
                        rd_q    <= MemRead;
                        wr_q    <= MemWrite;
                        cnt_q   <= CNT_INIT;
                        state_q <= (LATENCY > 1) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    cnt_q <= 4'(cnt_q - 4'd1);
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    if (!access_err) begin
                        if (rd_q) begin
                            rdata_q <= mem_q[idx];
                        end
                        if (wr_q) begin
                            mem_q[idx] <= wdata_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dReadData = rdata_q;
    assign MemReady  = ready_q;
    assign MemError  = error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=2 and LATENCY=1).
module tb_dmem_responder;

    localparam int unsigned LAT = 2;

    logic        clk;
    logic        rst;

    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic [31:0] rdata;
    logic        ready;
    logic        error;

    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic        rd1;
    logic        wr1;
    logic [31:0] rdata1;
    logic        ready1;
    logic        error1;

    int unsigned nchecks = 0;
    int unsigned nerrors = 0;

    logic [31:0] got_data;
    logic        got_err;

    dmem_responder #(
        .DEPTH_WORDS (32),
        .LATENCY     (LAT),
        .AW          (32)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .dAddress   (addr),
        .dWriteData (wdata),
        .MemRead    (rd),
        .MemWrite   (wr),
        .dReadData  (rdata),
        .MemReady   (ready),
        .MemError   (error)
    );

    dmem_responder #(
        .DEPTH_WORDS (32),
        .LATENCY     (1),
        .AW          (32)
    ) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .dAddress   (addr1),
        .dWriteData (wdata1),
        .MemRead    (rd1),
        .MemWrite   (wr1),
        .dReadData  (rdata1),
        .MemReady   (ready1),
        .MemError   (error1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request right after a clock edge, wait (bounded) for MemReady,
    // check the latency and that the pulse lasts exactly one cycle.
    task automatic access(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic r, input logic w,
                          output logic [31:0] data_o, output logic err_o);
        int unsigned k;
        addr  = a;
        wdata = d;
        rd    = r;
        wr    = w;
        @(posedge clk);
        k = 0;
        for (int unsigned n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) begin
                k = n;
                break;
            end
        end
        rd = 1'b0;
        wr = 1'b0;
        check({tag, "_latency"}, k, LAT);
        data_o = rdata;
        err_o  = error;
        @(posedge clk);
        #1;
        check({tag, "_pulse_end"}, {31'd0, ready}, 32'd0);
    endtask

    initial begin
        rst    = 1'b0;
        addr   = '0;
        wdata  = '0;
        rd     = 1'b0;
        wr     = 1'b0;
        addr1  = '0;
        wdata1 = '0;
        rd1    = 1'b0;
        wr1    = 1'b0;

        // 1. reset for 3 cycles, release, idle outputs, load of empty word
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_rdata", rdata, 32'h0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        access("ld10", 32'h10, 32'h0, 1'b1, 1'b0, got_data, got_err);
        check("ld10_data", got_data, 32'h0);
        check("ld10_err", {31'd0, got_err}, 32'd0);

        // 2. store then load back
        access("st08", 32'h08, 32'hDEADBEEF, 1'b0, 1'b1, got_data, got_err);
        check("st08_err", {31'd0, got_err}, 32'd0);
        access("ld08", 32'h08, 32'h0, 1'b1, 1'b0, got_data, got_err);
        check("ld08_data", got_data, 32'hDEADBEEF);
        check("ld08_err", {31'd0, got_err}, 32'd0);

        // 3. misaligned / out-of-range rejections; storage untouched
        access("ld06", 32'h06, 32'h0, 1'b1, 1'b0, got_data, got_err);
        check("ld06_err", {31'd0, got_err}, 32'd1);
        check("ld06_hold", got_data, 32'hDEADBEEF);
        access("ld80", 32'h80, 32'h0, 1'b1, 1'b0, got_data, got_err);
        check("ld80_err", {31'd0, got_err}, 32'd1);
        check("ld80_hold", got_data, 32'hDEADBEEF);
        access("st80", 32'h80, 32'hAAAA5555, 1'b0, 1'b1, got_data, got_err);
        check("st80_err", {31'd0, got_err}, 32'd1);
        access("st0a", 32'h0A, 32'h11111111, 1'b0, 1'b1, got_data, got_err);
        check("st0a_err", {31'd0, got_err}, 32'd1);
        access("ld00", 32'h00, 32'h0, 1'b1, 1'b0, got_data, got_err);
        check("ld00_data", got_data, 32'h0);
        access("ld08b", 32'h08, 32'h0, 1'b1, 1'b0, got_data, got_err);
        check("ld08b_data", got_data, 32'hDEADBEEF);
        access("st7c", 32'h7C, 32'hCAFEF00D, 1'b0, 1'b1, got_data, got_err);
        check("st7c_err", {31'd0, got_err}, 32'd0);
        access("ld7c", 32'h7C, 32'h0, 1'b1, 1'b0, got_data, got_err);
        check("ld7c_data", got_data, 32'hCAFEF00D);
        check("ld7c_err", {31'd0, got_err}, 32'd0);

        // 4. read+write conflict is rejected and does not write
        access("rw04", 32'h04, 32'h12345678, 1'b1, 1'b1, got_data, got_err);
        check("rw04_err", {31'd0, got_err}, 32'd1);
        check("rw04_hold", got_data, 32'hCAFEF00D);
        access("ld04", 32'h04, 32'h0, 1'b1, 1'b0, got_data, got_err);
        check("ld04_data", got_data, 32'h0);
        access("ld08c", 32'h08, 32'h0, 1'b1, 1'b0, got_data, got_err);
        check("ld08c_data", got_data, 32'hDEADBEEF);

        // 6. reset while a store to 0x0C is waiting
        addr  = 32'h0C;
        wdata = 32'h55AA55AA;
        wr    = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rstw_rdata", rdata, 32'h0);
        check("rstw_ready", {31'd0, ready}, 32'd0);
        check("rstw_error", {31'd0, error}, 32'd0);
        wr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        access("ld0c", 32'h0C, 32'h0, 1'b1, 1'b0, got_data, got_err);
        check("ld0c_data", got_data, 32'h0);
        check("ld0c_err", {31'd0, got_err}, 32'd0);
        access("ld08d", 32'h08, 32'h0, 1'b1, 1'b0, got_data, got_err);
        check("ld08d_data", got_data, 32'h0);

        // 5. LATENCY=1 with the request held: MemReady every second cycle
        addr1 = 32'h10;
        rd1   = 1'b1;
        for (int unsigned k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("l1_ready_%0d", k), {31'd0, ready1}, (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        check("l1_error", {31'd0, error1}, 32'd0);
        check("l1_rdata", rdata1, 32'h0);
        rd1 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
